// File: rtl/mult_iterative.sv
// mult_iterative: sequential WIDTH x WIDTH -> 2*WIDTH multiplier (MIPS mult/multu).
// Radix-2 shift-add on magnitudes, one iteration per clock, sign fixed up at the end.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      request a new multiply (accepted in IDLE or DONE only)
//   is_signed  1 = two's complement operands, 0 = unsigned; sampled with start
//   a, b       multiplicand / multiplier; sampled with start
//   busy       high while the state is RUN
//   done       one-cycle pulse when hi/lo carry a new result
//   hi, lo     registered product halves, held until the next done
module mult_iterative #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_COUNT = 6'(ITER - 1);

  // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    if (sgn && v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  // Two's-complement negation across the full product width.
  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    negate = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t               state_r;
  state_t               state_next_s;
  logic                 accept_s;
  logic                 last_s;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     mag_a_r;
  logic                 neg_r;
  logic [5:0]           count_r;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   acc_step_s;
  logic [2*WIDTH-1:0]   result_s;
  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Next-state logic and start acceptance.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = (count_r == LAST_COUNT);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // One shift-add iteration: conditional add into the upper WIDTH+1 bits
  // (carry kept), folded together with the right shift by one.
  always_comb begin
    sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    if (acc_r[0]) begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_r};
    end else begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
    if (neg_r) begin
      result_s = negate(acc_step_s);
    end else begin
      result_s = acc_step_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= {(2*WIDTH){1'b0}};
      mag_a_r <= {WIDTH{1'b0}};
      neg_r   <= 1'b0;
      count_r <= 6'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_next_s == RUN);
      done_r <= (state_next_s == DONE);
      if (accept_s) begin
        acc_r   <= {{WIDTH{1'b0}}, magnitude(b, is_signed)};
        mag_a_r <= magnitude(a, is_signed);
        neg_r   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        count_r <= 6'd0;
      end else if (state_r == RUN) begin
        acc_r   <= acc_step_s;
        count_r <= count_r + 6'd1;
        if (last_s) begin
          hi_r <= result_s[2*WIDTH-1:WIDTH];
          lo_r <= result_s[WIDTH-1:0];
        end
      end
    end
  end

endmodule
